// File: rtl/distribute_1x2_out_buffer_pkg.sv
// Shared definitions for the 1x2 distribute output buffer: lane indices,
// the idle-lane data value and the occupancy-counter width helper.
package distribute_1x2_out_buffer_pkg;

  typedef enum logic {
    LANE_LOW  = 1'b0,
    LANE_HIGH = 1'b1
  } lane_e;

  // Value presented on an idle lane; sliced down to the payload/cmd width.
  localparam logic [255:0] DUMMY_DATA = '0;

  // Occupancy counters need one extra bit so that "full" (== depth) is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/distribute_1x2_out_buffer_if.sv
// Handshake/bus bundle between the distribute switch, this buffer and the
// next tree level. The slave modport is the buffer's view.
interface distribute_1x2_out_buffer_if #(
  parameter int DATA_WIDTH         = 32,
  parameter int CMD_WIDTH_PER_DATA = 1,
  parameter int FIFO_DEPTH         = 4
) ();
  import distribute_1x2_out_buffer_pkg::*;

  localparam int CNT_W = count_width(FIFO_DEPTH);

  logic [1:0]                      i_valid;
  logic [2*DATA_WIDTH-1:0]         i_data_bus;
  logic [2*CMD_WIDTH_PER_DATA-1:0] i_cmd;
  logic                            o_en;
  logic [1:0]                      o_valid;
  logic [2*DATA_WIDTH-1:0]         o_data_bus;
  logic [2*CMD_WIDTH_PER_DATA-1:0] o_cmd;
  logic [1:0]                      i_ready;
  logic [2*CNT_W-1:0]              o_count;

  modport master (
    output i_valid, i_data_bus, i_cmd, i_ready,
    input  o_en, o_valid, o_data_bus, o_cmd, o_count
  );

  modport slave (
    input  i_valid, i_data_bus, i_cmd, i_ready,
    output o_en, o_valid, o_data_bus, o_cmd, o_count
  );

endinterface

// File: rtl/distribute_1x2_out_buffer_lane_fifo.sv
// Single-lane synchronous FIFO holding {cmd, data} entries. A full FIFO
// refuses a push even when it pops in the same cycle.
module distribute_lane_fifo
  import distribute_1x2_out_buffer_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  parameter int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Qualify push/pop against occupancy and compute next pointers/count.
  always_comb begin
    push_ok  = push_i && (count_q != FULL_CNT);
    pop_ok   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards all stored entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; stale contents are harmless because the head is qualified by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/distribute_1x2_out_buffer.sv
// Registered output stage behind the 1x2 destination-tag distribute switch.
// Two independent lane FIFOs; a single enable back to the switch stalls both
// lanes whenever either one is full.
// Optional feature macro: DISTRIBUTE_OUT_BUF_BYPASS_EN -- an empty lane whose
// consumer is ready passes the incoming beat straight through with zero latency.
module distribute_1x2_out_buffer
  import distribute_1x2_out_buffer_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int CMD_WIDTH_PER_DATA = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input logic clk,
  input logic rst,
  distribute_1x2_out_buffer_if.slave bus
);

  localparam int               CNT_W    = count_width(FIFO_DEPTH);
  localparam int               DW       = DATA_WIDTH;
  localparam int               CW       = CMD_WIDTH_PER_DATA;
  localparam int               ENTRY_W  = CW + DW;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic               en;
  logic [1:0]         push, pop, bypass, fifo_valid, valid_out;
  logic [ENTRY_W-1:0] lane_in    [2];
  logic [ENTRY_W-1:0] fifo_head  [2];
  logic [CNT_W-1:0]   fifo_count [2];
  logic [2*DW-1:0]    data_out;
  logic [2*CW-1:0]    cmd_out;
  logic [2*CNT_W-1:0] count_out;

  // Enable depends only on registered counts, never on downstream ready.
  assign en = !rst && (fifo_count[LANE_HIGH] < FULL_CNT) && (fifo_count[LANE_LOW] < FULL_CNT);

  for (genvar k = 0; k < 2; k++) begin : g_lane
    assign lane_in[k] = {bus.i_cmd[k*CW +: CW], bus.i_data_bus[k*DW +: DW]};

    distribute_lane_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[k]),
      .pop_i   (pop[k]),
      .wdata_i (lane_in[k]),
      .rdata_o (fifo_head[k]),
      .valid_o (fifo_valid[k]),
      .count_o (fifo_count[k])
    );
  end

  // Per-lane push/pop decisions, optional bypass and output muxing with idle zeros.
  always_comb begin
    push      = '0;
    pop       = '0;
    bypass    = '0;
    valid_out = '0;
    data_out  = '0;
    cmd_out   = '0;
    count_out = '0;
    for (int k = 0; k < 2; k++) begin
`ifdef DISTRIBUTE_OUT_BUF_BYPASS_EN
      bypass[k] = (fifo_count[k] == '0) && bus.i_valid[k] && en && bus.i_ready[k];
`endif
      push[k]      = bus.i_valid[k] && en && !bypass[k];
      pop[k]       = fifo_valid[k] && bus.i_ready[k];
      valid_out[k] = fifo_valid[k] || bypass[k];
      if (fifo_valid[k]) begin
        data_out[k*DW +: DW] = fifo_head[k][DW-1:0];
        cmd_out[k*CW +: CW]  = fifo_head[k][ENTRY_W-1 -: CW];
      end else if (bypass[k]) begin
        data_out[k*DW +: DW] = lane_in[k][DW-1:0];
        cmd_out[k*CW +: CW]  = lane_in[k][ENTRY_W-1 -: CW];
      end else begin
        data_out[k*DW +: DW] = DUMMY_DATA[DW-1:0];
        cmd_out[k*CW +: CW]  = DUMMY_DATA[CW-1:0];
      end
      count_out[k*CNT_W +: CNT_W] = fifo_count[k];
    end
  end

  assign bus.o_en       = en;
  assign bus.o_valid    = valid_out;
  assign bus.o_data_bus = data_out;
  assign bus.o_cmd      = cmd_out;
  assign bus.o_count    = count_out;

endmodule
